// File: rtl/wbdbgbus_pipe_ram.sv
// Pipelined Wishbone B4 slave RAM with fixed response latency, optional periodic
// stall injection and range/forced error responses.
module wbdbgbus_pipe_ram #(
    parameter int MEMORY_DEPTH = 128,
    parameter int LATENCY      = 2,
    parameter int STALL_PERIOD = 0,
    parameter int ERR_ON_RANGE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        i_force_stall,
    input  logic        i_force_error
);

    localparam int AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic [31:0]   mem [MEMORY_DEPTH];
    resp_t         pipe [LATENCY];
    resp_t         resp_in;
    logic [SW-1:0] scnt;
    logic [AW-1:0] widx;
    logic          accept;
    logic          in_range;
    logic          do_write;

    assign o_wb_stall = i_force_stall
                      | ((STALL_PERIOD != 0) && (scnt == SW'(STALL_PERIOD - 1)));

    assign in_range = (i_wb_addr < 32'(MEMORY_DEPTH));
    assign widx     = i_wb_addr[AW-1:0];
    assign accept   = i_wb_cyc & i_wb_stb & ~o_wb_stall & ~i_rst;
    assign do_write = accept & i_wb_we & in_range & ~i_force_error;

    // Free-running stall phase counter; only advances inside a bus cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_wb_cyc || STALL_PERIOD == 0)
            scnt <= '0;
        else if (scnt == SW'(STALL_PERIOD - 1))
            scnt <= '0;
        else
            scnt <= scnt + 1'b1;
    end

    // Response entering the pipeline; forced error outranks the range check.
    always_comb begin
        resp_in = '0;
        if (accept) begin
            if (i_force_error) begin
                resp_in.err = 1'b1;
            end else if (!in_range) begin
                if (ERR_ON_RANGE != 0)
                    resp_in.err = 1'b1;
                else
                    resp_in.ack = 1'b1;
            end else begin
                resp_in.ack = 1'b1;
                if (!i_wb_we)
                    resp_in.data = mem[widx];
            end
        end
    end

    // NOTE: the RAM array has no reset; clearing storage would force a per-word
    // reset network and the contents must survive reset anyway.
    always_ff @(posedge i_clk) begin
        if (do_write)
            mem[widx] <= i_wb_data;
    end

    // Dropping cyc or reset discards every in-flight response.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_wb_cyc) begin
            for (int i = 0; i < LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= resp_in;
            for (int i = 1; i < LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign o_wb_ack  = pipe[LATENCY-1].ack;
    assign o_wb_err  = pipe[LATENCY-1].err;
    assign o_wb_data = pipe[LATENCY-1].data;

endmodule

// File: tb/tb_wbdbgbus_pipe_ram.sv
// Self-checking bench for wbdbgbus_pipe_ram: table-driven traffic plus scoreboards
// for a default instance, an ack-on-range instance and a stall-injecting instance.
module tb_wbdbgbus_pipe_ram;

    localparam int LAT = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ferr;
        logic        oor;
        logic        eack;
        logic        eerr;
        logic [31:0] edata;
    } vec_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, fstall = 1'b0, ferr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        cyc_s = 1'b0, stb_s = 1'b0, we_s = 1'b0;
    logic [31:0] addr_s = '0, wdata_s = '0;

    logic        ack_m, err_m, stall_m, ack_r, err_r, stall_r, ack_s, err_s, stall_s;
    logic [31:0] dat_m, dat_r, dat_s;

    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;
    exp_t q_m[$], q_r[$], q_s[$];
    vec_t tbl[20];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wbdbgbus_pipe_ram #(.MEMORY_DEPTH(128), .LATENCY(LAT), .STALL_PERIOD(0), .ERR_ON_RANGE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack_m), .o_wb_err(err_m),
        .o_wb_stall(stall_m), .o_wb_data(dat_m), .i_force_stall(fstall), .i_force_error(ferr));

    wbdbgbus_pipe_ram #(.MEMORY_DEPTH(128), .LATENCY(LAT), .STALL_PERIOD(0), .ERR_ON_RANGE(0)) dut_r (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack_r), .o_wb_err(err_r),
        .o_wb_stall(stall_r), .o_wb_data(dat_r), .i_force_stall(fstall), .i_force_error(ferr));

    wbdbgbus_pipe_ram #(.MEMORY_DEPTH(128), .LATENCY(LAT), .STALL_PERIOD(3), .ERR_ON_RANGE(1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc_s), .i_wb_stb(stb_s), .i_wb_we(we_s),
        .i_wb_addr(addr_s), .i_wb_data(wdata_s), .o_wb_ack(ack_s), .o_wb_err(err_s),
        .o_wb_stall(stall_s), .o_wb_data(dat_s), .i_force_stall(1'b0), .i_force_error(1'b0));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic fe, input logic o, input logic ea,
                                input logic ee, input logic [31:0] ed);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.ferr = fe; v.oor = o;
        v.eack = ea; v.eerr = ee; v.edata = ed;
        return v;
    endfunction

    // Scoreboard monitor: outputs sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (ack_m | err_m) begin
            check("m_sb_nonempty", 64'(q_m.size() != 0), 1);
            if (q_m.size() != 0) begin
                e = q_m.pop_front();
                check("m_resp", {ack_m, err_m, dat_m}, {e.ack, e.err, e.data});
                check("m_latency", cyc_cnt, e.cyc);
            end
        end
        if (ack_r | err_r) begin
            check("r_sb_nonempty", 64'(q_r.size() != 0), 1);
            if (q_r.size() != 0) begin
                e = q_r.pop_front();
                check("r_resp", {ack_r, err_r, dat_r}, {e.ack, e.err, e.data});
                check("r_latency", cyc_cnt, e.cyc);
            end
        end
        if (ack_s | err_s) begin
            check("s_sb_nonempty", 64'(q_s.size() != 0), 1);
            if (q_s.size() != 0) begin
                e = q_s.pop_front();
                check("s_resp", {ack_s, err_s, dat_s}, {e.ack, e.err, e.data});
                check("s_latency", cyc_cnt, e.cyc);
            end
        end
        check("m_clean", {ack_m & err_m, !ack_m && dat_m != 0}, 0);
        check("r_clean", {ack_r & err_r, !ack_r && dat_r != 0}, 0);
        check("s_clean", {ack_s & err_s, !ack_s && dat_s != 0}, 0);
    end

    // Drive one request to the shared bus (called at a falling edge) and push
    // the expectation for both the default and the ack-on-range instance.
    task automatic drive_main(input vec_t v);
        exp_t e;
        cyc = 1'b1; stb = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; ferr = v.ferr;
        e.ack = v.eack; e.err = v.eerr; e.data = v.edata; e.cyc = cyc_cnt + LAT;
        q_m.push_back(e);
        if (v.oor && !v.ferr) begin
            e.ack = 1'b1; e.err = 1'b0; e.data = '0;
        end
        q_r.push_back(e);
        @(negedge clk);
        stb = 1'b0; ferr = 1'b0;
    endtask

    task automatic drain_main(input string name);
        stb = 1'b0;
        for (int k = 0; k < 20 && (q_m.size() != 0 || q_r.size() != 0); k++)
            @(negedge clk);
        check({name, "_m"}, q_m.size(), 0);
        check({name, "_r"}, q_r.size(), 0);
    endtask

    initial begin
        int scnt_m;
        int i;
        int guard;
        logic exp_stall;
        exp_t e;

        //              we    addr           wdata         ferr oor  ack  err  data
        tbl[0]  = mk(1'b1, 32'd0,        32'h10,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 32'd1,        32'h11,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[2]  = mk(1'b1, 32'd2,        32'h12,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[3]  = mk(1'b1, 32'd3,        32'h13,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[4]  = mk(1'b1, 32'd5,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 32'd5,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        tbl[6]  = mk(1'b0, 32'd0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h10);
        tbl[7]  = mk(1'b0, 32'd1,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h11);
        tbl[8]  = mk(1'b0, 32'd2,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h12);
        tbl[9]  = mk(1'b0, 32'd3,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h13);
        tbl[10] = mk(1'b1, 32'd7,        32'h55,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[11] = mk(1'b1, 32'd7,        32'h1234,     1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        tbl[12] = mk(1'b0, 32'd7,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h55);
        tbl[13] = mk(1'b0, 32'd128,      32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        tbl[14] = mk(1'b1, 32'd200,      32'hFFFF,     1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        tbl[15] = mk(1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        tbl[16] = mk(1'b1, 32'd127,      32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[17] = mk(1'b0, 32'd127,      32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
        tbl[18] = mk(1'b1, 32'd128,      32'h9999,     1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        tbl[19] = mk(1'b0, 32'd0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h10);

        repeat (3) @(negedge clk);
        check("rst_m", {ack_m, err_m, dat_m}, 0);
        check("rst_r", {ack_r, err_r, dat_r}, 0);
        check("rst_s", {ack_s, err_s, dat_s}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back table traffic with cyc held high throughout.
        cyc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive_main(tbl[k]);
            stb = 1'b1;
        end
        drain_main("tbl_drain");

        // Forced stall holds off acceptance; the request goes through once released.
        fstall = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'd1;
        repeat (2) begin
            #1 check("fstall", stall_m, 1);
            @(negedge clk);
        end
        fstall = 1'b0;
        drive_main(mk(1'b0, 32'd1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11));
        drain_main("fstall_drain");

        // Abort: two reads accepted, cyc dropped before the second responds.
        drive_main(mk(1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10));
        stb = 1'b1; we = 1'b0; addr = 32'd2;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        repeat (6) @(negedge clk);
        cyc = 1'b1;
        drive_main(mk(1'b0, 32'd5, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF));
        drain_main("abort_drain");
        cyc = 1'b0;

        // Stall injection every third cycle: 6 writes then 6 read-backs.
        @(negedge clk);
        cyc_s = 1'b1; stb_s = 1'b1;
        scnt_m = 0; i = 0; guard = 0;
        while (i < 12 && guard < 100) begin
            we_s = (i < 6); addr_s = 32'(i % 6); wdata_s = 32'h100 + 32'(i);
            exp_stall = (scnt_m == 2);
            #1 check("s_stall", stall_s, exp_stall);
            if (!exp_stall) begin
                e.ack = 1'b1; e.err = 1'b0; e.cyc = cyc_cnt + LAT;
                e.data = (i < 6) ? 32'h0 : 32'h100 + 32'(i - 6);
                q_s.push_back(e);
            end
            @(posedge clk);
            scnt_m = (scnt_m == 2) ? 0 : scnt_m + 1;
            if (!exp_stall) i++;
            @(negedge clk);
            guard++;
        end
        check("s_issued", i, 12);
        stb_s = 1'b0;
        for (int k = 0; k < 20 && q_s.size() != 0; k++) @(negedge clk);
        check("s_drain", q_s.size(), 0);
        cyc_s = 1'b0;

        // Reset mid-transfer: the write response is discarded but the data stays.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'd9; wdata = 32'h77;
        @(negedge clk);
        stb = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        drive_main(mk(1'b0, 32'd9, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77));
        drain_main("rst_drain");
        cyc = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
